// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t  : controller state encoding
//   REG_ZERO : register number of the hard-wired zero register
//   sat_inc  : saturating increment used by the performance counters
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Increments val but never past the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection.
//   ex_memread  in  : instruction in EX is a load
//   ex_rt       in  : load destination register
//   id_rs       in  : source rs of instruction in ID
//   id_rt       in  : source rt of instruction in ID
//   id_uses_rt  in  : instruction in ID actually reads rt
//   lu_hazard   out : ID instruction needs the load result not yet available
import pipe_ctrl_pkg::*;

module hazard_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       lu_hazard
);

  // A load into the zero register never produces a dependency.
  assign lu_hazard = ex_memread && (ex_rt != REG_ZERO) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing control for a 5-stage pipeline: post-reset fill, load-use
// stalls, MEM-resolved branch/jump flushes and data-memory wait freezes.
//   clk, rst_n        : clock, async active-low reset
//   id_rs/id_rt       : source registers in IF/ID; id_uses_rt qualifies rt
//   ex_memread/ex_rt  : load in ID/EX and its destination
//   mem_branch/mem_zero/mem_jump : branch resolution in EX/MEM
//   mem_access        : data-memory access in EX/MEM
//   pc_we/ifid_we/back_we        : PC, IF/ID and back-end register enables
//   ifid_flush/idex_bubble/exmem_flush : NOP insertion controls
//   wb_inhibit        : blocks RegWrite/MemWrite while the pipe fills
//   stall_count/flush_count      : saturating performance counters
//
// state | meaning
// FILL  | after reset, pipe advances with writes inhibited
// RUN   | normal operation, hazards handled by priority
// MWAIT | frozen for remaining data-memory wait cycles
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int FILL_CYCLES = 4,
  parameter int MEM_WAIT    = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             mem_access,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             back_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             wb_inhibit,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int              FILL_W    = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam logic [FILL_W-1:0] FILL_INIT = FILL_W'(FILL_CYCLES - 1);
  localparam logic [3:0]      WAIT_INIT = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;
  localparam bit              WAIT_EN   = (MEM_WAIT > 0);
  localparam bit              WAIT_ONE  = (MEM_WAIT == 1);

  state_t            state, state_nxt;
  logic [FILL_W-1:0] fill_cnt, fill_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic              served, served_nxt;
  logic              stall_inc, flush_inc;
  logic              lu_hazard;
  logic              taken;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .lu_hazard  (lu_hazard)
  );

  assign taken = (mem_branch && mem_zero) || mem_jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      fill_cnt    <= FILL_INIT;
      wait_cnt    <= 4'd0;
      served      <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      wait_cnt <= wait_nxt;
      served   <= served_nxt;
      if (stall_inc) stall_count <= CNT_W'(sat_inc(64'(stall_count), CNT_W));
      if (flush_inc) flush_count <= CNT_W'(sat_inc(64'(flush_count), CNT_W));
    end
  end

  always_comb begin
    state_nxt   = state;
    fill_nxt    = fill_cnt;
    wait_nxt    = wait_cnt;
    served_nxt  = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    back_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    wb_inhibit  = 1'b0;

    case (state)
      FILL: begin
        idex_bubble = 1'b1;
        wb_inhibit  = 1'b1;
        if (fill_cnt == '0) state_nxt = RUN;
        else                fill_nxt  = fill_cnt - FILL_W'(1);
      end

      RUN, MWAIT: begin
        if (state == MWAIT && wait_cnt != 4'd0) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          back_we   = 1'b0;
          wait_nxt  = wait_cnt - 4'd1;
          stall_inc = 1'b1;
        end else begin
          state_nxt = RUN;
          if (taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (WAIT_EN && mem_access && state == RUN && !served) begin
            // First freeze cycle of an access. The wait-end cycle (MWAIT with
            // wait_cnt==0, or the served cycle for a single-cycle wait) must
            // not restart the wait even though EX/MEM still shows the access.
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            back_we   = 1'b0;
            wait_nxt  = WAIT_INIT;
            stall_inc = 1'b1;
            if (WAIT_ONE) served_nxt = 1'b1;
            else          state_nxt  = MWAIT;
          end else if (lu_hazard) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      end

      default: state_nxt = FILL;
    endcase

    // Outputs must show their reset values the moment rst_n falls, not at
    // the next edge.
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      back_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      exmem_flush = 1'b0;
      wb_inhibit  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int FILL_CYCLES = 4;
  localparam int MEM_WAIT    = 2;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic             mem_branch = 1'b0, mem_zero = 1'b0, mem_jump = 1'b0, mem_access = 1'b0;
  logic             pc_we, ifid_we, back_we, ifid_flush, idex_bubble, exmem_flush, wb_inhibit;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipe_hazard_ctrl #(
    .FILL_CYCLES (FILL_CYCLES),
    .MEM_WAIT    (MEM_WAIT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_memread  (ex_memread),
    .ex_rt       (ex_rt),
    .mem_branch  (mem_branch),
    .mem_zero    (mem_zero),
    .mem_jump    (mem_jump),
    .mem_access  (mem_access),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .back_we     (back_we),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_flush (exmem_flush),
    .wb_inhibit  (wb_inhibit),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles of fill left, freeze cycles left for the current
  // memory access, and whether the cycle after a freeze is the advance cycle.
  int m_fill_left, m_freeze_left, m_stalls, m_flushes;
  bit m_adv_due;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fill_left   = FILL_CYCLES;
    m_freeze_left = 0;
    m_adv_due     = 1'b0;
    m_stalls      = 0;
    m_flushes     = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc_we"},   32'(pc_we),       32'd0);
    check({tag, "_ifid_we"}, 32'(ifid_we),     32'd0);
    check({tag, "_back_we"}, 32'(back_we),     32'd0);
    check({tag, "_iff"},     32'(ifid_flush),  32'd0);
    check({tag, "_bubble"},  32'(idex_bubble), 32'd1);
    check({tag, "_exf"},     32'(exmem_flush), 32'd0);
    check({tag, "_inhibit"}, 32'(wb_inhibit),  32'd1);
    check({tag, "_stalls"},  32'(stall_count), 32'd0);
    check({tag, "_flushes"}, 32'(flush_count), 32'd0);
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs with
  // the model, then advance the model across the rising edge.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                      input bit mr, input logic [4:0] ert, input bit br, input bit z,
                      input bit j, input bit acc, input bit chk);
    bit e_pc, e_ifid, e_back, e_iff, e_bub, e_exf, e_inh;
    bit taken, lu, freeze_now, start_wait, stall_now, flush_now;
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_rt = ert;
    mem_branch = br; mem_zero = z; mem_jump = j; mem_access = acc;
    #1;
    taken = (br && z) || j;
    lu    = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
    {freeze_now, start_wait, stall_now, flush_now} = 4'b0;
    {e_pc, e_ifid, e_back} = 3'b111;
    {e_iff, e_bub, e_exf, e_inh} = 4'b0;
    if (m_fill_left > 0) begin
      e_bub = 1'b1; e_inh = 1'b1;
    end else if (m_freeze_left > 0) begin
      freeze_now = 1'b1;
    end else if (taken) begin
      e_iff = 1'b1; e_bub = 1'b1; e_exf = 1'b1; flush_now = 1'b1;
    end else if (!m_adv_due && acc && MEM_WAIT > 0) begin
      freeze_now = 1'b1; start_wait = 1'b1;
    end else if (lu) begin
      e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1; stall_now = 1'b1;
    end
    if (freeze_now) {e_pc, e_ifid, e_back} = 3'b000;
    if (chk) begin
      check("pc_we",       32'(pc_we),       32'(e_pc));
      check("ifid_we",     32'(ifid_we),     32'(e_ifid));
      check("back_we",     32'(back_we),     32'(e_back));
      check("ifid_flush",  32'(ifid_flush),  32'(e_iff));
      check("idex_bubble", 32'(idex_bubble), 32'(e_bub));
      check("exmem_flush", 32'(exmem_flush), 32'(e_exf));
      check("wb_inhibit",  32'(wb_inhibit),  32'(e_inh));
      check("stall_count", 32'(stall_count), 32'(m_stalls));
      check("flush_count", 32'(flush_count), 32'(m_flushes));
    end
    @(posedge clk);
    if (m_fill_left > 0)        m_fill_left--;
    else if (m_freeze_left > 0) m_freeze_left--;
    else if (start_wait)        begin m_freeze_left = MEM_WAIT - 1; m_adv_due = 1'b1; end
    else                        m_adv_due = 1'b0;
    if ((freeze_now || stall_now) && m_stalls < CNT_MAX) m_stalls++;
    if (flush_now && m_flushes < CNT_MAX) m_flushes++;
    #1;
  endtask

  task automatic idle(input bit chk);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, chk);
  endtask

  initial begin
    logic [4:0] r_rs, r_rt, r_ert;
    bit r_urt, r_mr, r_br, r_z, r_j, r_acc;

    // Reset state and fill
    model_reset();
    #12;
    check_reset("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (FILL_CYCLES) idle(1'b1);
    check("fill_done_inhibit", 32'(wb_inhibit), 32'd0);
    check("fill_done_bubble",  32'(idex_bubble), 32'd0);

    // Load-use on rs, then ex_rt=0 which must not stall
    step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lu_stall_count", 32'(stall_count), 32'd1);
    step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lu_zero_reg", 32'(stall_count), 32'd1);
    // Load-use through rt only when id_uses_rt
    step(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lu_rt_count", 32'(stall_count), 32'd2);

    // Taken branch with simultaneous load-use: flush wins
    step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("br_flush_count", 32'(flush_count), 32'd1);
    check("br_stall_same",  32'(stall_count), 32'd2);
    // Jump together with mem_access: flush wins, no wait
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("jmp_acc_flush", 32'(flush_count), 32'd2);
    check("jmp_acc_stall", 32'(stall_count), 32'd2);

    // Memory wait: two freeze cycles, then advance
    repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mwait_stall_count", 32'(stall_count), 32'd4);
    idle(1'b1);

    // Reset asserted between edges while in MWAIT
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (FILL_CYCLES + 1) idle(1'b1);

    // Randomized operation
    for (int i = 0; i < 400; i++) begin
      r_rs  = 5'($urandom_range(0, 3));
      r_rt  = 5'($urandom_range(0, 3));
      r_ert = 5'($urandom_range(0, 3));
      r_urt = 1'($urandom_range(0, 1));
      r_mr  = 1'($urandom_range(0, 1));
      r_br  = ($urandom_range(0, 5) == 0);
      r_z   = 1'($urandom_range(0, 1));
      r_j   = ($urandom_range(0, 15) == 0);
      r_acc = ($urandom_range(0, 4) == 0);
      step(r_rs, r_rt, r_urt, r_mr, r_ert, r_br, r_z, r_j, r_acc, 1'b1);
    end

    // Counter saturation under a held load-use hazard
    for (int i = 0; i < 70000; i++)
      step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_stall_count", 32'(stall_count), 32'(CNT_MAX));
    step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_no_wrap", 32'(stall_count), 32'(CNT_MAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
